// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: 3-digit BCD stopwatch/event-counter core with prescaled tick and terminal-count detect.
// Optional macro BCD_CTRL_SYNC_EN adds 2-flop synchronizers on start/stop/clear.
module bcd_count_ctrl #(
  parameter int PRESCALE = 4,
  parameter int PS_W = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic [11:0] limit,
  input  logic        auto_reload,
  output logic [11:0] bcd_q,
  output logic        running,
  output logic        done,
  output logic        load_err
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state, state_n;
  logic [PS_W-1:0] ps, ps_n;
  logic [11:0] bcd_n, inc, nxt_val;
  logic pend, pend_n, done_n, err_n;
  logic sta, stp, clr;
  logic tick, c0, c1, c2, ld_ok, hit;
`ifdef BCD_CTRL_SYNC_EN
  logic [2:0] s1, s2;
  always_ff @(posedge clk)
    if (reset) {s1, s2} <= '0;
    else begin
      s1 <= {clear, stop, start};
      s2 <= s1;
    end
  assign {clr, stp, sta} = s2;
`else
  assign {clr, stp, sta} = {clear, stop, start};
`endif
  assign c0 = bcd_q[3:0] == 4'd9;
  assign c1 = c0 && bcd_q[7:4] == 4'd9;
  assign c2 = c1 && bcd_q[11:8] == 4'd9;
  assign inc = {c2 ? 4'd0 : c1 ? bcd_q[11:8] + 4'd1 : bcd_q[11:8],
                c1 ? 4'd0 : c0 ? bcd_q[7:4] + 4'd1 : bcd_q[7:4],
                c0 ? 4'd0 : bcd_q[3:0] + 4'd1};
  // a pending auto-reload replaces the next increment with 000
  assign nxt_val = pend ? 12'h000 : inc;
  assign hit = nxt_val == limit;
  assign tick = state == RUN && ps == PS_W'(PRESCALE - 1);
  assign ld_ok = load_val[3:0] <= 4'd9 && load_val[7:4] <= 4'd9 && load_val[11:8] <= 4'd9;
  always_comb begin
    state_n = state;
    bcd_n = bcd_q;
    ps_n = ps;
    pend_n = pend;
    done_n = 1'b0;
    err_n = 1'b0;
    if (clr) begin
      state_n = IDLE;
      bcd_n = 12'h000;
      ps_n = '0;
      pend_n = 1'b0;
    end else if (load && state != RUN) begin
      if (ld_ok) begin
        state_n = IDLE;
        bcd_n = load_val;
        ps_n = '0;
        pend_n = 1'b0;
      end else err_n = 1'b1;
    end else if (!load && stp && state == RUN) state_n = PAUSE;
    else if (!load && sta && (state == IDLE || state == PAUSE)) state_n = RUN;
    else if (state == RUN) begin
      ps_n = tick ? '0 : ps + 1'b1;
      if (tick) begin
        bcd_n = nxt_val;
        pend_n = hit && auto_reload;
        done_n = hit;
        state_n = hit && !auto_reload ? DONE : RUN;
      end
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      bcd_q <= 12'h000;
      ps <= '0;
      pend <= 1'b0;
      running <= 1'b0;
      done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state <= state_n;
      bcd_q <= bcd_n;
      ps <= ps_n;
      pend <= pend_n;
      running <= state_n == RUN;
      done <= done_n;
      load_err <= err_n;
    end
endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb_bcd_count_ctrl: directed checks of bcd_count_ctrl with PRESCALE=4.
module tb_bcd_count_ctrl;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0, auto_reload = 1'b0;
  logic [11:0] load_val = 12'h000, limit = 12'h500, bcd_q;
  logic running, done, load_err;
  int total = 0, bad = 0;
  bcd_count_ctrl #(.PRESCALE(4), .PS_W(17)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .load(load),
    .load_val(load_val), .limit(limit), .auto_reload(auto_reload),
    .bcd_q(bcd_q), .running(running), .done(done), .load_err(load_err)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask
  task automatic do_load(input logic [11:0] v);
    load_val = v; load = 1'b1; step(1); load = 1'b0;
  endtask
  task automatic do_clear();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask
  initial begin
    step(2);
    chk("rst_bcd", bcd_q, 12'h000);
    chk("rst_run", {11'd0, running}, 12'd0);
    chk("rst_done", {11'd0, done}, 12'd0);
    chk("rst_err", {11'd0, load_err}, 12'd0);
    reset = 1'b0;
    pulse_start();
    chk("start_run", {11'd0, running}, 12'd1);
    chk("start_bcd", bcd_q, 12'h000);
    step(3); chk("pre_tick", bcd_q, 12'h000);
    step(1); chk("tick1", bcd_q, 12'h001);
    step(4); chk("tick2", bcd_q, 12'h002);
    do_clear();
    chk("clr_bcd", bcd_q, 12'h000);
    chk("clr_run", {11'd0, running}, 12'd0);
    limit = 12'h500;
    do_load(12'h998);
    chk("ld998", bcd_q, 12'h998);
    pulse_start();
    step(4); chk("to999", bcd_q, 12'h999);
    step(4); chk("wrap000", bcd_q, 12'h000);
    chk("wrap_nodone", {11'd0, done}, 12'd0);
    step(4); chk("wrap001", bcd_q, 12'h001);
    chk("wrap_run", {11'd0, running}, 12'd1);
    do_clear();
    limit = 12'h099; auto_reload = 1'b0;
    do_load(12'h097);
    pulse_start();
    step(4); chk("h098", bcd_q, 12'h098);
    step(3); chk("h_nodone", {11'd0, done}, 12'd0);
    step(1); chk("h099", bcd_q, 12'h099);
    chk("h_done", {11'd0, done}, 12'd1);
    chk("h_stopped", {11'd0, running}, 12'd0);
    step(1); chk("h_done_pulse", {11'd0, done}, 12'd0);
    pulse_start();
    step(4); chk("h_hold", bcd_q, 12'h099);
    chk("h_norun", {11'd0, running}, 12'd0);
    auto_reload = 1'b1;
    do_load(12'h097);
    chk("ar_ld", bcd_q, 12'h097);
    pulse_start();
    step(4); chk("ar098", bcd_q, 12'h098);
    step(4); chk("ar099", bcd_q, 12'h099);
    chk("ar_done", {11'd0, done}, 12'd1);
    chk("ar_run", {11'd0, running}, 12'd1);
    step(1); chk("ar_done_pulse", {11'd0, done}, 12'd0);
    step(3); chk("ar000", bcd_q, 12'h000);
    chk("ar_run2", {11'd0, running}, 12'd1);
    do_clear();
    limit = 12'h500; auto_reload = 1'b0;
    do_load(12'h1A3);
    chk("bad_err", {11'd0, load_err}, 12'd1);
    chk("bad_bcd", bcd_q, 12'h000);
    step(1); chk("bad_err_pulse", {11'd0, load_err}, 12'd0);
    do_load(12'h123);
    chk("ld123", bcd_q, 12'h123);
    pulse_start();
    do_load(12'h456);
    chk("run_ld_ign", bcd_q, 12'h123);
    chk("run_ld_noerr", {11'd0, load_err}, 12'd0);
    chk("run_ld_run", {11'd0, running}, 12'd1);
    stop = 1'b1; clear = 1'b1; step(1); stop = 1'b0; clear = 1'b0;
    chk("stpclr_bcd", bcd_q, 12'h000);
    chk("stpclr_run", {11'd0, running}, 12'd0);
    pulse_start();
    step(3);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("stop_tick_bcd", bcd_q, 12'h000);
    chk("stop_tick_run", {11'd0, running}, 12'd0);
    pulse_start();
    chk("resume_run", {11'd0, running}, 12'd1);
    chk("resume_bcd", bcd_q, 12'h000);
    step(1); chk("resume_held", bcd_q, 12'h001);
    reset = 1'b1; step(1); reset = 1'b0;
    chk("rst2_bcd", bcd_q, 12'h000);
    chk("rst2_run", {11'd0, running}, 12'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
Sequencing controller for the 12-bit, 3-digit BCD increment datapath. It holds the BCD count register and drives the incrementor enable from a prescaled tick. It accepts start/stop/clear/load commands and detects the terminal count. It sits between the user control logic and the 7-segment display driver, acting as the stopwatch/event-counter core.

Parameters:
PRESCALE, 4, clk cycles per count tick (>=1); sim default 4, top level overrides (e.g. 100000).
PS_W, 17, prescaler counter width; must satisfy 2^PS_W >= PRESCALE.

Ports:
clk  in  1  system clock, all logic rising-edge.
reset  in  1  synchronous, active-high reset.
start  in  1  level-sampled command: begin/resume counting.
stop  in  1  command: pause counting.
clear  in  1  command: count <= 000, go IDLE.
load  in  1  command: count <= load_val.
load_val  in  12  BCD value for load, 3 nibbles.
limit  in  12  BCD terminal count.
auto_reload  in  1  1 = restart at 000 after limit, 0 = halt at limit.
bcd_q  out  12  current BCD count, registered.
running  out  1  high in RUN.
done  out  1  one-cycle pulse when limit reached.
load_err  out  1  one-cycle pulse on rejected load.

Behaviour:
- Reset is synchronous and active-high on clk. On reset: bcd_q=000, state=IDLE, prescaler=0, running=0, done=0, load_err=0.
- States are IDLE, RUN, PAUSE and DONE. running=1 only in RUN.
- Command priority each cycle: clear > load > stop > start. Only the highest asserted command acts.
- clear: from any state, bcd_q<=000, prescaler<=0, state<=IDLE.
- load: accepted in IDLE, PAUSE or DONE.
  - If every nibble of load_val is <=9: bcd_q<=load_val, prescaler<=0, state<=IDLE.
  - If any nibble is >9: bcd_q unchanged, load_err pulses for 1 cycle.
  - load in RUN is ignored; no error pulse.
- start: IDLE->RUN and PAUSE->RUN. Ignored in DONE; clear or load is required first.
- stop: RUN->PAUSE. The prescaler value is held, so resuming continues the partial tick.
- Prescaler:
  - In RUN it counts 0..PRESCALE-1. tick=1 in the cycle prescaler==PRESCALE-1, then it wraps to 0.
  - The prescaler is frozen outside RUN.
  - With PRESCALE=1, tick is asserted every RUN cycle.
- Increment: the incrementor en is driven by tick & RUN. bcd_q takes the incremented value at that edge, so there is 1 cycle latency from tick to the new bcd_q.
- Limit detection: evaluated on the value about to be written.
  - If next==limit: done pulses in the same cycle that bcd_q becomes limit.
  - auto_reload=0: state<=DONE, bcd_q holds limit.
  - auto_reload=1: state stays RUN, and the next tick writes 000 instead of the increment.
- Wrap-around: 999+1 -> 000 whenever limit != 000. No done pulse; count continues.
- limit == current bcd_q at start: no immediate done. The count must wrap fully to reach it again.
- Invalid limit (nibble >9): never matches, so the counter free-runs.
- Simultaneous events: stop arriving with a tick in RUN means stop wins and no increment occurs. clear arriving with limit reached means clear wins and there is no done pulse.
- Reset mid-count returns every output to its reset value on the next edge.
- All outputs are registered except none; done and load_err are registered one-cycle pulses.

Optional Feature:
- Macro: BCD_CTRL_SYNC_EN.
- Defined: start, stop and clear each pass through a 2-flop synchronizer (flops reset to 0) before command decode. This adds 2 cycles of command latency and makes them safe for asynchronous button inputs.
- Undefined: commands are decoded in the same cycle they are sampled. Latency figures in Test Plan assume the macro is undefined.

Test Plan:
- reset; start=1 for 1 cycle, PRESCALE=4 -> running=1 next cycle; bcd_q goes 000->001 after 4 RUN cycles, 002 after 8.
- load_val=12'h998, load, limit=12'h500, start -> bcd_q 999, then 000, then 001; no done, running stays 1.
- load 12'h097, limit=12'h099, auto_reload=0, start -> done pulses 1 cycle as bcd_q=099; state DONE; further start ignored, bcd_q holds 099.
- Same setup with auto_reload=1 -> done pulse at 099, next tick bcd_q=000, running=1.
- load_val=12'h1A3 -> load_err pulses 1 cycle, bcd_q unchanged. Assert load in RUN -> ignored, no load_err.
- Assert stop and clear in the same cycle during RUN -> bcd_q=000, IDLE. Assert stop on a tick cycle -> PAUSE, no increment; start resumes with prescaler held.
